// File: rtl/lsram_access_controller_pkg.sv
// rtl/lsram_access_controller_pkg.sv - LSRAM geometry helpers and controller types; LSRAM_PIPE_REG_EN selects read latency
package LSRAM_package;

  typedef enum logic [2:0] {
    RAM16Kx1,
    RAM8Kx2,
    RAM4Kx4,
    RAM2Kx9,
    RAM1Kx18,
    RAM512x36
  } mode_type;

  typedef enum logic {
    INIT,
    RUN
  } ctrl_state_t;

`ifdef LSRAM_PIPE_REG_EN
  localparam int RD_LATENCY = 3;
`else
  localparam int RD_LATENCY = 2;
`endif

  function automatic int data_width_fn(mode_type mode);
    case (mode)
      RAM16Kx1:  return 1;
      RAM8Kx2:   return 2;
      RAM4Kx4:   return 4;
      RAM2Kx9:   return 9;
      RAM1Kx18:  return 18;
      RAM512x36: return 36;
      default:   return 18;
    endcase
  endfunction

  function automatic int addr_depth_fn(mode_type mode);
    case (mode)
      RAM16Kx1:  return 16384;
      RAM8Kx2:   return 8192;
      RAM4Kx4:   return 4096;
      RAM2Kx9:   return 2048;
      RAM1Kx18:  return 1024;
      RAM512x36: return 512;
      default:   return 1024;
    endcase
  endfunction

  function automatic int lsram_addr_width_fn(mode_type mode);
    return $clog2(addr_depth_fn(mode));
  endfunction

endpackage

// File: rtl/lsram_access_controller_if.sv
// rtl/lsram_access_controller_if.sv - request/response channels and LSRAM port signals of the controller
interface lsram_access_controller_if #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 10
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  awe;
  logic [ADDR_WIDTH-1:0] aaddr;
  logic [DATA_WIDTH-1:0] adin;
  logic [ADDR_WIDTH-1:0] baddr;
  logic [DATA_WIDTH-1:0] bdout;

  // master: requester plus the LSRAM itself; slave: the controller
  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready, bdout,
    input  wr_ready, rd_ready, rsp_valid, rsp_data, awe, aaddr, adin, baddr
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, rsp_ready, bdout,
    output wr_ready, rd_ready, rsp_valid, rsp_data, awe, aaddr, adin, baddr
  );
endinterface

// File: rtl/lsram_access_controller_rsp_fifo.sv
// rtl/lsram_access_controller_rsp_fifo.sv - synchronous in-order response FIFO with head-of-queue output
module lsram_rsp_fifo #(
  parameter int DATA_WIDTH = 18,
  parameter int DEPTH      = 4
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full
);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]           r_wptr;
  logic [PW:0]           r_rptr;

  // extra pointer bit distinguishes full from empty
  assign empty = (r_wptr == r_rptr);
  assign full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign dout  = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push && !full) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (pop && !empty) begin
        r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (push && !full) begin
      r_mem[r_wptr[PW-1:0]] <= din;
    end
  end
endmodule

// File: rtl/lsram_access_controller.sv
// rtl/lsram_access_controller.sv - LSRAM port A write / port B read initiator with init, collision stall and credit flow control
// LSRAM_PIPE_REG_EN: attached LSRAM has its read pipeline register enabled (read latency 3)
module lsram_access_controller
  import LSRAM_package::*;
#(
  parameter mode_type              MODE       = RAM1Kx18,
  parameter int                    DATA_WIDTH = data_width_fn(MODE),
  parameter int                    ADDR_WIDTH = lsram_addr_width_fn(MODE),
  parameter int                    RSP_DEPTH  = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                     aclk,
  input  logic                     rst,
  output logic                     init_done,
  lsram_access_controller_if.slave bus
);
  localparam int CW = $clog2(RSP_DEPTH) + 1;

  ctrl_state_t           r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                  r_awe, w_awe_nxt;
  logic [ADDR_WIDTH-1:0] r_aaddr, w_aaddr_nxt;
  logic [DATA_WIDTH-1:0] r_adin, w_adin_nxt;
  logic [ADDR_WIDTH-1:0] r_baddr;
  logic [CW-1:0]         r_credit;
  logic [RD_LATENCY-1:0] r_vpipe;

  logic w_run, w_collision, w_wr_hs, w_rd_hs, w_rsp_hs;
  logic w_fifo_empty, w_fifo_full;

  assign w_run       = (r_state == RUN);
  assign w_collision = bus.wr_valid && bus.rd_valid && (bus.wr_addr == bus.rd_addr);

  // the fifo-full term is implied by the credit limit and only guards against misuse
  assign bus.wr_ready = w_run;
  assign bus.rd_ready = w_run && (r_credit < CW'(RSP_DEPTH)) && !w_collision && !w_fifo_full;

  assign w_wr_hs  = bus.wr_valid && bus.wr_ready;
  assign w_rd_hs  = bus.rd_valid && bus.rd_ready;
  assign w_rsp_hs = !w_fifo_empty && bus.rsp_ready;

  assign init_done     = w_run;
  assign bus.awe       = r_awe;
  assign bus.aaddr     = r_aaddr;
  assign bus.adin      = r_adin;
  assign bus.baddr     = r_baddr;
  assign bus.rsp_valid = !w_fifo_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_awe_nxt   = 1'b0;
    w_aaddr_nxt = r_aaddr;
    w_adin_nxt  = r_adin;
    case (r_state)
      INIT: begin
        w_awe_nxt   = 1'b1;
        w_aaddr_nxt = r_cnt;
        w_adin_nxt  = INIT_VALUE;
        w_cnt_nxt   = r_cnt + 1'b1;
        if (&r_cnt) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (w_wr_hs) begin
          w_awe_nxt   = 1'b1;
          w_aaddr_nxt = bus.wr_addr;
          w_adin_nxt  = bus.wr_data;
        end
      end
      default: w_state_nxt = INIT;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      r_state <= INIT;
      r_cnt   <= '0;
      r_awe   <= 1'b0;
      r_aaddr <= '0;
      r_adin  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_awe   <= w_awe_nxt;
      r_aaddr <= w_aaddr_nxt;
      r_adin  <= w_adin_nxt;
    end
  end

  // one valid bit per LSRAM read stage; the last stage marks bdout as capturable
  always_ff @(posedge aclk) begin
    if (rst) begin
      r_baddr  <= '0;
      r_vpipe  <= '0;
      r_credit <= '0;
    end else begin
      if (w_rd_hs) begin
        r_baddr <= bus.rd_addr;
      end
      r_vpipe <= {r_vpipe[RD_LATENCY-2:0], w_rd_hs};
      case ({w_rd_hs, w_rsp_hs})
        2'b10:   r_credit <= r_credit + 1'b1;
        2'b01:   r_credit <= r_credit - 1'b1;
        default: r_credit <= r_credit;
      endcase
    end
  end

  lsram_rsp_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (RSP_DEPTH)
  ) u_rsp_fifo (
    .aclk (aclk),
    .rst  (rst),
    .push (r_vpipe[RD_LATENCY-1]),
    .pop  (w_rsp_hs),
    .din  (bus.bdout),
    .dout (bus.rsp_data),
    .empty(w_fifo_empty),
    .full (w_fifo_full)
  );
endmodule

// File: tb/tb_lsram_access_controller.sv
// tb/tb_lsram_access_controller.sv - directed scoreboard bench for lsram_access_controller with an LSRAM behavioural model
module tb_lsram_access_controller;
  import LSRAM_package::*;

  localparam int              DW    = 18;
  localparam int              AW    = 10;
  localparam int              WORDS = 1024;
  localparam logic [DW-1:0]   INITV = 18'h3_FFFF;

  logic aclk = 1'b0;
  logic rst  = 1'b1;
  logic init_done;

  always #5 aclk = ~aclk;

  lsram_access_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  lsram_access_controller #(
    .MODE      (RAM1Kx18),
    .RSP_DEPTH (4),
    .INIT_VALUE(INITV)
  ) dut (
    .aclk     (aclk),
    .rst      (rst),
    .init_done(init_done),
    .bus      (bus)
  );

  // LSRAM: port A synchronous write, port B synchronous read, optional output register
  logic [DW-1:0] ram [WORDS];
  logic [DW-1:0] q1, q2;
  always @(posedge aclk) begin
    if (bus.awe) ram[bus.aaddr] <= bus.adin;
    q1 <= ram[bus.baddr];
    q2 <= q1;
  end
  assign bus.bdout = (RD_LATENCY == 3) ? q2 : q1;

  logic [DW-1:0] shadow [WORDS];
  logic [DW-1:0] exp_q [$];
  int  tests = 0;
  int  fails = 0;
  logic last_rd_hs, last_wr_hs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // evaluate handshakes just before the edge, then advance one clock
  task automatic tick();
    logic [DW-1:0] e;
    #1;
    last_rd_hs = 1'b0;
    last_wr_hs = 1'b0;
    if (!rst) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 32'(bus.rsp_data), 32'(e));
        end
      end
      if (bus.rd_valid && bus.rd_ready) begin
        exp_q.push_back(shadow[bus.rd_addr]);
        last_rd_hs = 1'b1;
      end
      if (bus.wr_valid && bus.wr_ready) begin
        shadow[bus.wr_addr] = bus.wr_data;
        last_wr_hs = 1'b1;
      end
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int b = 0;
    bus.wr_valid = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    do begin tick(); b++; end while (!last_wr_hs && b < 50);
    bus.wr_valid = 1'b0;
    if (!last_wr_hs) check("wr_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int b = 0;
    bus.rd_valid = 1'b1; bus.rd_addr = a;
    do begin tick(); b++; end while (!last_rd_hs && b < 50);
    bus.rd_valid = 1'b0;
    if (!last_rd_hs) check("rd_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int b = 0;
    bus.rsp_ready = 1'b1;
    while (exp_q.size() > 0 && b < 50) begin tick(); b++; end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_init(input string tag, output logic saw_rsp);
    int n = 0;
    saw_rsp = 1'b0;
    while (!init_done && n < 2000) begin
      tick();
      n++;
      if (bus.rsp_valid) saw_rsp = 1'b1;
      if (n == 1) begin
        check({tag, "_awe"}, 32'(bus.awe), 32'd1);
        check({tag, "_aaddr0"}, 32'(bus.aaddr), 32'd0);
        check({tag, "_adin"}, 32'(bus.adin), 32'(INITV));
      end
      if (n == 10) begin
        check({tag, "_aaddr9"}, 32'(bus.aaddr), 32'd9);
        check({tag, "_rd_ready"}, 32'(bus.rd_ready), 32'd0);
        check({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd0);
      end
    end
    check({tag, "_cycles"}, 32'(n), 32'd1024);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw;
    int   acc;
    int   b;
    bus.wr_valid = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_valid = 1'b0; bus.rd_addr = '0; bus.rsp_ready = 1'b1;
    for (int i = 0; i < WORDS; i++) shadow[i] = INITV;

    repeat (3) tick();
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    check("rst_rd_ready", 32'(bus.rd_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_awe", 32'(bus.awe), 32'd0);
    check("rst_aaddr", 32'(bus.aaddr), 32'd0);
    check("rst_adin", 32'(bus.adin), 32'd0);
    check("rst_baddr", 32'(bus.baddr), 32'd0);

    // requests offered during init must be ignored
    rst = 1'b0;
    bus.wr_valid = 1'b1; bus.wr_addr = 10'd5; bus.wr_data = 18'h1234;
    bus.rd_valid = 1'b1; bus.rd_addr = 10'd5;
    wait_init("init", saw);
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
    check("init_no_rsp", 32'(saw), 32'd0);

    do_read(10'd0); do_read(10'd511); do_read(10'd1023); do_read(10'd5);
    drain();

    do_write(10'h12, 18'h2AB5);
    do_read(10'h12);
    for (int n = 1; n <= RD_LATENCY; n++) begin
      tick();
      check("rd_latency", 32'(bus.rsp_valid), 32'(n == RD_LATENCY));
    end
    check("wr_rd_data", 32'(bus.rsp_data), 32'h2AB5);
    drain();

    do_write(10'h40, 18'h0);
    bus.wr_valid = 1'b1; bus.wr_addr = 10'h40; bus.wr_data = 18'h1111;
    bus.rd_valid = 1'b1; bus.rd_addr = 10'h40;
    #1;
    check("coll_rd_ready", 32'(bus.rd_ready), 32'd0);
    check("coll_wr_ready", 32'(bus.wr_ready), 32'd1);
    tick();
    bus.wr_valid = 1'b0;
    #1;
    check("coll_rd_ready_next", 32'(bus.rd_ready), 32'd1);
    tick();
    bus.rd_valid = 1'b0;
    drain();

    bus.wr_valid = 1'b1; bus.wr_addr = 10'h41; bus.wr_data = 18'h0AAA;
    bus.rd_valid = 1'b1; bus.rd_addr = 10'h42;
    #1;
    check("diff_rd_ready", 32'(bus.rd_ready), 32'd1);
    tick();
    bus.wr_valid = 1'b0; bus.rd_valid = 1'b0;
    do_read(10'h41);
    drain();

    for (int i = 1; i <= 6; i++) do_write(AW'(i), DW'(18'h100 + i));
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      bus.rd_valid = 1'b1; bus.rd_addr = AW'(1 + acc);
      tick();
      if (last_rd_hs) acc++;
    end
    check("bp_accepted", 32'(acc), 32'd4);
    check("bp_rd_ready", 32'(bus.rd_ready), 32'd0);
    check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("bp_head", 32'(bus.rsp_data), 32'h101);
    tick();
    check("bp_head_stable", 32'(bus.rsp_data), 32'h101);
    bus.rsp_ready = 1'b1;
    b = 0;
    while (acc < 6 && b < 50) begin
      bus.rd_valid = 1'b1; bus.rd_addr = AW'(1 + acc);
      tick();
      if (last_rd_hs) acc++;
      b++;
    end
    bus.rd_valid = 1'b0;
    check("bp_all_accepted", 32'(acc), 32'd6);
    drain();

    // leave two reads buffered and two still in the LSRAM pipeline, then reset
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      bus.rd_valid = 1'b1; bus.rd_addr = AW'(7 + i);
      tick();
      if (last_rd_hs) acc++;
    end
    check("mid_accepted", 32'(acc), 32'd4);
    rst = 1'b1; bus.rd_valid = 1'b0;
    tick();
    check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_init_done", 32'(init_done), 32'd0);
    exp_q.delete();
    for (int i = 0; i < WORDS; i++) shadow[i] = INITV;
    tick();
    rst = 1'b0;
    wait_init("reinit", saw);
    check("reinit_no_stale", 32'(saw), 32'd0);
    tick(); tick();
    check("reinit_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    bus.rsp_ready = 1'b1;
    acc = 0; b = 0;
    while (acc < WORDS && b < 4000) begin
      bus.rd_valid = 1'b1; bus.rd_addr = AW'(acc);
      tick();
      if (last_rd_hs) acc++;
      b++;
    end
    bus.rd_valid = 1'b0;
    check("full_sweep_accepted", 32'(acc), 32'(WORDS));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lsram_access_controller.md
Name: lsram_access_controller

Overview:
Single-clock initiator that drives a two-port-mode LSRAM instance: port A write and port B read. It turns valid/ready write and read request channels into LSRAM port signals and returns read data on a valid/ready response channel. It prevents same-cycle read/write collisions at the same address, which the LSRAM does not detect. After every reset it initialises the whole array.

Parameters:
MODE, RAM1Kx18, LSRAM_package::mode_type geometry of the attached LSRAM
DATA_WIDTH, LSRAM_package::data_width_fn(MODE), word width
ADDR_WIDTH, $clog2(LSRAM_package::addr_depth_fn(MODE)), address width
RSP_DEPTH, 4, response FIFO entries; also the maximum number of reads in flight plus buffered (power of 2, ≥2)
INIT_VALUE, '0, word written to every location during initialisation

Ports:
aclk  in  1  clock; the LSRAM aclk and bclk both connect here
rst  in  1  synchronous, active-high reset
init_done  out  1  high once initialisation has completed
wr_valid  in  1  write request valid
wr_ready  out  1  write request ready
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
rd_valid  in  1  read request valid
rd_ready  out  1  read request ready
rd_addr  in  ADDR_WIDTH  read address
rsp_valid  out  1  read data valid
rsp_ready  in  1  read data accepted
rsp_data  out  DATA_WIDTH  read data
awe  out  1  LSRAM port A write enable
aaddr  out  ADDR_WIDTH  LSRAM port A address
adin  out  DATA_WIDTH  LSRAM port A data
baddr  out  ADDR_WIDTH  LSRAM port B address
bdout  in  DATA_WIDTH  LSRAM port B read data

Behaviour:
- Reset values: init_done=0, wr_ready=0, rd_ready=0, rsp_valid=0, awe=0, aaddr=0, adin=0, baddr=0. State is INIT, init counter is 0, credit counter is 0, FIFO is empty.
- States:
  - INIT: each cycle awe=1, aaddr=counter, adin=INIT_VALUE, then counter+1. After writing address 2**ADDR_WIDTH-1, move to RUN. This takes exactly 2**ADDR_WIDTH cycles.
  - RUN: init_done=1 (registered). There is no exit from RUN except rst.
- Request channels are ignored in INIT (wr_ready=rd_ready=0).
- Writes:
  - In RUN, wr_ready=1 every cycle.
  - A handshake at edge k produces awe=1, aaddr=wr_addr, adin=wr_data registered for the cycle after edge k.
  - Otherwise awe=0.
  - Throughput is one write per cycle.
- Reads:
  - rd_ready = RUN && credit<RSP_DEPTH && !collision.
  - A handshake at edge k registers baddr=rd_addr for the cycle after k.
  - A pipeline valid bit tracks the read. bdout is captured into the FIFO at edge k+2.
  - rsp_valid is high from the cycle after k+2, giving a read latency of 2.
- Collision: collision = wr_valid && rd_valid && wr_addr==rd_addr.
  - The write proceeds; the read is stalled for that cycle.
  - The read then reaches the LSRAM one cycle after the write and returns the newly written data.
  - A read and a write to different addresses in the same cycle both proceed.
- Credit counter:
  - +1 on rd handshake; −1 on rsp handshake; unchanged when both occur in the same cycle.
  - It never exceeds RSP_DEPTH, so the FIFO can never overflow and in-flight data is never dropped.
- Response FIFO: in-order. rsp_data = head entry. rsp_valid = FIFO not empty. rsp_data holds stable while rsp_valid=1 && rsp_ready=0.
- Reset mid-operation: in-flight reads are discarded, the FIFO is flushed, the credit counter is cleared, and the array is re-initialised (INIT restarts at address 0).
- Request inputs are never registered while the corresponding ready=0.

Optional Feature:
LSRAM_PIPE_REG_EN
- Defined: the attached LSRAM has its optional read pipeline register enabled. Read latency becomes 3; capture happens at edge k+3 and the valid pipeline is one stage longer. Credit accounting is unchanged.
- Undefined: read latency is 2 as above.

Decomposition:
- LSRAM_package gains:
  - ctrl_state_t enum {INIT, RUN}
  - localparam RD_LATENCY (2, or 3 when LSRAM_PIPE_REG_EN is defined)
  - lsram_addr_width_fn(mode)
- One sub-module: lsram_rsp_fifo, a synchronous FIFO.
  - Parameters: DATA_WIDTH and DEPTH.
  - Ports: push, pop, din, dout, empty, full, with aclk and rst.

Test Plan:
- Init, MODE=RAM1Kx18, INIT_VALUE=18'h3_FFFF: release rst → init_done rises after 1024 cycles; reads of 0, 511 and 1023 return 18'h3_FFFF.
- Write/read: write 0x12→0x2AB5, then read 0x12 on the next cycle → rsp_data=0x2AB5 with rsp_valid exactly 2 cycles after the read handshake.
- Collision: same cycle wr(0x40, 0x1111) and rd(0x40), prior content 0 → rd_ready=0 that cycle, read accepted next cycle, rsp_data=0x1111.
- Back-pressure, RSP_DEPTH=4, rsp_ready=0: issue 6 back-to-back reads of 1..6 → exactly 4 accepted, rd_ready=0 afterwards. Raising rsp_ready returns data for 1..4 in order, then reads 5 and 6 are accepted.
- Reset mid-operation: assert rst with 2 reads in flight and 2 responses buffered → rsp_valid=0 the next cycle, no stale responses after re-init, and all locations read INIT_VALUE.
- With LSRAM_PIPE_REG_EN: repeat the write/read test → rsp_valid appears 3 cycles after the read handshake with data 0x2AB5.
